// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/status bus between multicycle controller and datapath
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [2:0] cpsr;
    logic       zero;
    logic       mem_ready;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       flags_we;

    // Controller side: consumes datapath status, drives every enable and select.
    modport master (
        input  opcode, cpsr, zero, mem_ready,
        output pc_we, pc_src, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, flags_we
    );

    // Datapath side: mirror image of the controller.
    modport slave (
        output opcode, cpsr, zero, mem_ready,
        input  pc_we, pc_src, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, flags_we
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore FSM sequencing a shared-ALU multicycle datapath
module multicycle_ctrl #(
    parameter int RCNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus,
    output logic              halted,
    output logic [3:0]        state,
    output logic [RCNT_W-1:0] retired
);

    localparam logic [5:0] OP_R    = 6'b00_0000;
    localparam logic [5:0] OP_LW   = 6'b10_0011;
    localparam logic [5:0] OP_SW   = 6'b10_1011;
    localparam logic [5:0] OP_BEQ  = 6'b00_0100;
    localparam logic [5:0] OP_J    = 6'b00_0010;
    localparam logic [5:0] OP_ADDI = 6'b00_1000;
    localparam logic [5:0] OP_BEN  = 6'b01_0100;
    localparam logic [5:0] OP_BVF  = 6'b01_0101;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MRD    = 4'd3,
        S_MWB    = 4'd4,
        S_MWR    = 4'd5,
        S_REXE   = 4'd6,
        S_RWB    = 4'd7,
        S_IEXE   = 4'd8,
        S_IWB    = 4'd9,
        S_BR     = 4'd10,
        S_JMP    = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              retire;
    logic [RCNT_W-1:0] retired_q;

    // State register; reset overrides any transition, including an in-flight store.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Retired-instruction counter, bumped on the last cycle of each instruction; wraps silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + RCNT_W'(1);
        end
    end

    // Next-state selection and per-state enables; unused encodings fall back to FETCH.
    always_comb begin
        state_d        = S_FETCH;
        retire         = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_src     = 2'd0;
        bus.ir_we      = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.reg_we     = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'd0;
        bus.alu_op     = 2'd0;
        bus.flags_we   = 1'b0;
        halted         = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.mem_rd    = 1'b1;
                bus.iord      = 1'b0;
                bus.alu_src_a = 1'b0;
                bus.alu_src_b = 2'd1;
                bus.alu_op    = 2'd0;
                bus.pc_src    = 2'd0;
                if (bus.mem_ready) begin
                    bus.ir_we = 1'b1;
                    bus.pc_we = 1'b1;
                    state_d   = S_DECODE;
                end else begin
                    state_d   = S_FETCH;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while the opcode is decoded.
                bus.alu_src_a = 1'b0;
                bus.alu_src_b = 2'd3;
                bus.alu_op    = 2'd0;
                case (bus.opcode)
                    OP_LW, OP_SW:          state_d = S_MADDR;
                    OP_R:                  state_d = S_REXE;
                    OP_ADDI:               state_d = S_IEXE;
                    OP_BEQ, OP_BEN, OP_BVF: state_d = S_BR;
                    OP_J:                  state_d = S_JMP;
                    default:               state_d = S_HALT;
                endcase
            end
            S_MADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.alu_op    = 2'd0;
                state_d       = (bus.opcode == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                bus.mem_rd = 1'b1;
                bus.iord   = 1'b1;
                state_d    = bus.mem_ready ? S_MWB : S_MRD;
            end
            S_MWB: begin
                bus.reg_we     = 1'b1;
                bus.reg_dst    = 1'b0;
                bus.mem_to_reg = 1'b1;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_MWR: begin
                bus.mem_wr = 1'b1;
                bus.iord   = 1'b1;
                retire     = bus.mem_ready;
                state_d    = bus.mem_ready ? S_FETCH : S_MWR;
            end
            S_REXE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd0;
                bus.alu_op    = 2'd2;
                bus.flags_we  = 1'b1;
                state_d       = S_RWB;
            end
            S_RWB: begin
                bus.reg_we     = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.mem_to_reg = 1'b0;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_IEXE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.alu_op    = 2'd0;
                bus.flags_we  = 1'b1;
                state_d       = S_IWB;
            end
            S_IWB: begin
                bus.reg_we     = 1'b1;
                bus.reg_dst    = 1'b0;
                bus.mem_to_reg = 1'b0;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_BR: begin
                // cpsr is {N,V,Z}; the datapath clears it while flags_we is high here.
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd0;
                bus.alu_op    = 2'd1;
                bus.pc_src    = 2'd1;
                bus.flags_we  = 1'b1;
                case (bus.opcode)
                    OP_BEQ:  bus.pc_we = bus.zero;
                    OP_BEN:  bus.pc_we = bus.cpsr[2] | bus.cpsr[0];
                    OP_BVF:  bus.pc_we = bus.cpsr[1];
                    default: bus.pc_we = 1'b0;
                endcase
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JMP: begin
                bus.pc_we  = 1'b1;
                bus.pc_src = 2'd2;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic        halted;
    logic [3:0]  state;
    logic [31:0] retired;
    int          vectors;
    int          errors;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.RCNT_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .halted  (halted),
        .state   (state),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_we, ir_we, mem_rd, mem_wr, reg_we, flags_we}
    function automatic logic [5:0] en();
        return {bus.pc_we, bus.ir_we, bus.mem_rd, bus.mem_wr, bus.reg_we, bus.flags_we};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land on the falling edge, where inputs are changed and outputs sampled.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        vectors       = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.opcode    = 6'b00_0000;
        bus.cpsr      = 3'b000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_state", 32'(state), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        // R-type add, no memory wait
        reset = 1'b0; bus.mem_ready = 1'b1; bus.opcode = 6'b00_0000; #1;
        check("r_fetch_en", 32'(en()), 32'b111000);
        check("r_fetch_srcb", 32'(bus.alu_src_b), 32'd1);
        tick(); #1;
        check("r_dec_state", 32'(state), 32'd1);
        check("r_dec_en", 32'(en()), 32'b000000);
        check("r_dec_srcb", 32'(bus.alu_src_b), 32'd3);
        tick(); #1;
        check("r_exe_state", 32'(state), 32'd6);
        check("r_exe_en", 32'(en()), 32'b000001);
        check("r_exe_aluop", 32'(bus.alu_op), 32'd2);
        tick(); #1;
        check("r_wb_state", 32'(state), 32'd7);
        check("r_wb_en", 32'(en()), 32'b000010);
        check("r_wb_dst", 32'(bus.reg_dst), 32'd1);
        check("r_wb_retired_old", retired, 32'd0);
        tick(); #1;
        check("r_done_state", 32'(state), 32'd0);
        check("r_done_retired", retired, 32'd1);

        // lw: one FETCH wait, then two MRD waits -> 8 cycles, retired = 2
        bus.opcode = 6'b10_0011; bus.mem_ready = 1'b0; #1;
        check("lw_fetch_wait_en", 32'(en()), 32'b001000);
        tick(); bus.mem_ready = 1'b1; #1;
        check("lw_fetch_state", 32'(state), 32'd0);
        check("lw_fetch_en", 32'(en()), 32'b111000);
        tick(); #1;
        check("lw_dec_state", 32'(state), 32'd1);
        tick(); #1;
        check("lw_maddr_state", 32'(state), 32'd2);
        check("lw_maddr_srcb", 32'(bus.alu_src_b), 32'd2);
        check("lw_maddr_srca", 32'(bus.alu_src_a), 32'd1);
        tick(); bus.mem_ready = 1'b0; #1;
        check("lw_mrd_w1", {26'd0, bus.iord, state, bus.mem_rd}, {26'd0, 1'b1, 4'd3, 1'b1});
        check("lw_mrd_w1_en", 32'(en()), 32'b001000);
        tick(); #1;
        check("lw_mrd_w2", {26'd0, bus.iord, state, bus.mem_rd}, {26'd0, 1'b1, 4'd3, 1'b1});
        tick(); bus.mem_ready = 1'b1; #1;
        check("lw_mrd_rdy", {26'd0, bus.iord, state, bus.mem_rd}, {26'd0, 1'b1, 4'd3, 1'b1});
        tick(); bus.mem_ready = 1'b0; #1;
        check("lw_mwb_state", 32'(state), 32'd4);
        check("lw_mwb_en", 32'(en()), 32'b000010);
        check("lw_mwb_m2r", {30'd0, bus.mem_to_reg, bus.reg_dst}, 32'b10);
        tick(); #1;
        check("lw_done_retired", retired, 32'd2);

        // ben taken (cpsr = N)
        bus.opcode = 6'b01_0100; bus.cpsr = 3'b100; bus.mem_ready = 1'b1;
        tick(); tick(); #1;
        check("ben_t_state", 32'(state), 32'd10);
        check("ben_t_en", 32'(en()), 32'b100001);
        check("ben_t_pcsrc", 32'(bus.pc_src), 32'd1);
        check("ben_t_aluop", 32'(bus.alu_op), 32'd1);
        tick(); #1;
        check("ben_t_retired", retired, 32'd3);

        // ben not taken (cpsr = 000)
        bus.cpsr = 3'b000;
        tick(); tick(); #1;
        check("ben_nt_state", 32'(state), 32'd10);
        check("ben_nt_en", 32'(en()), 32'b000001);
        tick(); #1;
        check("ben_nt_retired", retired, 32'd4);

        // beq taken on zero, bvf not taken with only N/Z set
        bus.opcode = 6'b00_0100; bus.zero = 1'b1;
        tick(); tick(); #1;
        check("beq_t_en", 32'(en()), 32'b100001);
        bus.zero = 1'b0; #1;
        check("beq_nt_en", 32'(en()), 32'b000001);
        tick();
        bus.opcode = 6'b01_0101; bus.cpsr = 3'b101;
        tick(); tick(); #1;
        check("bvf_nt_en", 32'(en()), 32'b000001);
        bus.cpsr = 3'b010; #1;
        check("bvf_t_en", 32'(en()), 32'b100001);
        tick(); #1;
        check("br_retired", retired, 32'd6);

        // addi: 4 cycles, writes rt
        bus.opcode = 6'b00_1000;
        tick(); tick(); #1;
        check("addi_exe_state", 32'(state), 32'd8);
        check("addi_exe_en", 32'(en()), 32'b000001);
        tick(); #1;
        check("addi_wb", {24'd0, state, en(), bus.reg_dst, bus.mem_to_reg}, {24'd0, 4'd9, 6'b000010, 1'b0, 1'b0});
        tick(); #1;
        check("addi_retired", retired, 32'd7);

        // sw interrupted by reset while waiting in MWR
        bus.opcode = 6'b10_1011;
        tick(); tick(); bus.mem_ready = 1'b0; tick(); #1;
        check("sw_mwr_state", 32'(state), 32'd5);
        check("sw_mwr_en", 32'(en()), 32'b000100);
        check("sw_mwr_iord", 32'(bus.iord), 32'd1);
        reset = 1'b1; bus.mem_ready = 1'b1;
        tick(); #1;
        check("sw_rst_state", 32'(state), 32'd0);
        check("sw_rst_memwr", 32'(bus.mem_wr), 32'd0);
        check("sw_rst_retired", retired, 32'd0);
        reset = 1'b0;

        // Illegal opcode halts; enables stay low for 10 cycles
        bus.opcode = 6'b11_1111;
        tick(); tick(); #1;
        for (int i = 0; i < 10; i++) begin
            check("halt_state", 32'(state), 32'd12);
            check("halt_flag", 32'(halted), 32'd1);
            check("halt_en", {24'd0, en(), bus.pc_src}, 32'd0);
            bus.mem_ready = i[0];
            tick(); #1;
        end
        reset = 1'b1;
        tick(); #1;
        check("halt_rst", {27'd0, halted, state}, 32'd0);
        reset = 1'b0; bus.mem_ready = 1'b0;

        // Counter wrap: preload all-ones, then a jump retires
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        check("wrap_preload", retired, 32'hFFFF_FFFF);
        bus.opcode = 6'b00_0010; bus.mem_ready = 1'b1;
        tick(); tick(); #1;
        check("j_state", 32'(state), 32'd11);
        check("j_en", {24'd0, en(), bus.pc_src}, {24'd0, 6'b100000, 2'd2});
        tick(); #1;
        check("j_wrap_retired", retired, 32'd0);
        check("j_done_state", 32'(state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Watchdog so the bench always ends on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
